// File: rtl/eth_tx_sched.sv
// eth_tx_sched: Ethernet transmit scheduler.
// Chooses the next frame for the packet sender: ARP reply > ARP request > UDP.
// It also owns the ARP cache: the target MAC, its valid flag and the reply timeout.
// Optional feature macro: ETH_SCHED_UNICAST_REFRESH_EN. When it is defined, an ARP
// request sent while the cache is valid is unicast to the cached MAC. When it is
// undefined, every ARP request is broadcast.
module eth_tx_sched #(
   parameter int CLK_PER_MS    = 100000,
   parameter int ARP_PERIOD_MS = 3000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  i_arp_op,
   input  logic [47:0] i_arp_mac,
   input  logic [31:0] i_arp_ip,
   input  logic [31:0] i_target_ip,
   input  logic        i_udp_req,
   input  logic        i_tx_sop,
   input  logic        i_tx_eop,
   output logic [3:0]  o_pkt_type,
   output logic [47:0] o_dst_mac,
   output logic [31:0] o_dst_ip,
   output logic        o_arp_valid,
   output logic        o_busy
);

   localparam int MS_W  = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int PER_W = (ARP_PERIOD_MS > 1) ? $clog2(ARP_PERIOD_MS) : 1;
   localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(CLK_PER_MS - 1);
   localparam logic [PER_W-1:0] PER_LAST = PER_W'(ARP_PERIOD_MS - 1);
   localparam logic [47:0]      BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   localparam logic [1:0] ARP_OP_REQ   = 2'd1;
   localparam logic [1:0] ARP_OP_REPLY = 2'd2;

   localparam logic [3:0] PT_NONE     = 4'd0;
   localparam logic [3:0] PT_ARP_REQ  = 4'd1;
   localparam logic [3:0] PT_ARP_RESP = 4'd2;
   localparam logic [3:0] PT_UDP      = 4'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_BUSY
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [MS_W-1:0]   ms_cnt;
   logic [PER_W-1:0]  per_cnt;
   logic              ms_tick;
   logic              per_exp;
   logic              req_pend;
   logic              resp_pend;
   logic              waiting;
   logic [47:0]       resp_mac;
   logic [31:0]       resp_ip;
   logic [47:0]       cache_mac;
   logic [47:0]       req_mac;
   logic              arp_match;
   logic              sop_armed;
   logic              req_sop;
   logic              resp_sop;
   logic              udp_withdraw;
   logic [3:0]        arb_type;
   logic [3:0]        type_nxt;
   logic [47:0]       mac_nxt;
   logic [31:0]       ip_nxt;
   logic              busy_nxt;

   assign ms_tick   = (ms_cnt == MS_LAST);
   assign per_exp   = ms_tick && (per_cnt == PER_LAST);
   assign arp_match = (i_arp_op == ARP_OP_REPLY) && (i_arp_ip == i_target_ip);

   // A sop counts only when a frame is armed; the armed type tells us what left.
   assign sop_armed = (state == ST_ARMED) && i_tx_sop;
   assign req_sop   = sop_armed && (o_pkt_type == PT_ARP_REQ);
   assign resp_sop  = sop_armed && (o_pkt_type == PT_ARP_RESP);

   // An armed UDP frame is dropped once its destination or its payload goes away.
   assign udp_withdraw = (o_pkt_type == PT_UDP) && (!o_arp_valid || !i_udp_req);

`ifdef ETH_SCHED_UNICAST_REFRESH_EN
   assign req_mac = o_arp_valid ? cache_mac : BCAST_MAC;
`else
   assign req_mac = BCAST_MAC;
`endif

   // Millisecond timebase and ARP period timer; an outgoing request restarts both.
   // NOTE: clocked state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ms_cnt  <= '0;
         per_cnt <= '0;
      end else if (req_sop) begin
         ms_cnt  <= '0;
         per_cnt <= '0;
      end else if (ms_tick) begin
         ms_cnt  <= '0;
         per_cnt <= (per_cnt == PER_LAST) ? '0 : per_cnt + 1'b1;
      end else begin
         ms_cnt <= ms_cnt + 1'b1;
      end
   end

   // Pending-frame flags, the latched reply destination and the ARP cache.
   // NOTE: the payload registers are reset too, so the outputs never carry X after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         req_pend    <= 1'b1;
         resp_pend   <= 1'b0;
         resp_mac    <= '0;
         resp_ip     <= '0;
         cache_mac   <= '0;
         o_arp_valid <= 1'b0;
         waiting     <= 1'b0;
      end else begin
         if (req_sop) begin
            req_pend <= 1'b0;
         end else if (per_exp) begin
            req_pend <= 1'b1;
         end

         // A new request beats the sop of the previous reply, so it is not lost.
         if (i_arp_op == ARP_OP_REQ) begin
            resp_pend <= 1'b1;
            resp_mac  <= i_arp_mac;
            resp_ip   <= i_arp_ip;
         end else if (resp_sop) begin
            resp_pend <= 1'b0;
         end

         // A matching reply beats a timeout in the same cycle.
         if (arp_match) begin
            cache_mac   <= i_arp_mac;
            o_arp_valid <= 1'b1;
            waiting     <= 1'b0;
         end else begin
            if (per_exp && waiting) begin
               o_arp_valid <= 1'b0;
            end
            if (req_sop) begin
               waiting <= 1'b1;
            end
         end
      end
   end

   // Fixed-priority choice among the frames that are ready to go.
   // NOTE: each always_comb assigns a default first so no latch is inferred.
   always_comb begin
      arb_type = PT_NONE;
      if (resp_pend) begin
         arb_type = PT_ARP_RESP;
      end else if (req_pend) begin
         arb_type = PT_ARP_REQ;
      end else if (i_udp_req && o_arp_valid) begin
         arb_type = PT_UDP;
      end
   end

   // State register and the registered sender-facing outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         o_pkt_type <= PT_NONE;
         o_dst_mac  <= BCAST_MAC;
         o_dst_ip   <= '0;
         o_busy     <= 1'b0;
      end else begin
         state      <= state_nxt;
         o_pkt_type <= type_nxt;
         o_dst_mac  <= mac_nxt;
         o_dst_ip   <= ip_nxt;
         o_busy     <= busy_nxt;
      end
   end

   // Next-state logic: arm, hand over on sop, release on eop or withdraw.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (arb_type != PT_NONE) begin
               state_nxt = ST_ARMED;
            end
         end
         ST_ARMED: begin
            if (i_tx_sop) begin
               state_nxt = ST_BUSY;
            end else if (udp_withdraw) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (i_tx_eop) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output logic: capture type and destination on arming, hold until release.
   always_comb begin
      type_nxt = o_pkt_type;
      mac_nxt  = o_dst_mac;
      ip_nxt   = o_dst_ip;
      busy_nxt = o_busy;
      case (state)
         ST_IDLE: begin
            type_nxt = arb_type;
            busy_nxt = (arb_type != PT_NONE);
            case (arb_type)
               PT_ARP_RESP: begin
                  mac_nxt = resp_mac;
                  ip_nxt  = resp_ip;
               end
               PT_ARP_REQ: begin
                  mac_nxt = req_mac;
                  ip_nxt  = i_target_ip;
               end
               PT_UDP: begin
                  mac_nxt = cache_mac;
                  ip_nxt  = i_target_ip;
               end
               default: ;
            endcase
         end
         ST_ARMED: begin
            if (!i_tx_sop && udp_withdraw) begin
               type_nxt = PT_NONE;
               busy_nxt = 1'b0;
            end
         end
         ST_BUSY: begin
            if (i_tx_eop) begin
               type_nxt = PT_NONE;
               busy_nxt = 1'b0;
            end
         end
         default: begin
            type_nxt = PT_NONE;
            busy_nxt = 1'b0;
         end
      endcase
   end

endmodule
